// File: rtl/chebyshev_recurrence_ctrl_pkg.sv
// Shared definitions for the Chebyshev recurrence sequencer: FSM encoding and
// saturation limit helpers used by the clip stage.
package chebyshev_recurrence_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        CALC = 2'd2
    } state_t;

    // Largest positive value representable in a wl-bit two's complement word.
    function automatic longint sat_max(input int wl);
        return (longint'(1) << (wl - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int wl);
        return -(longint'(1) << (wl - 1));
    endfunction

endpackage

// File: rtl/chebyshev_recurrence_ctrl_clip.sv
// Combinational signed saturator: narrows an IW-bit value to WL bits and
// reports whether clipping occurred.
module chebyshev_clip
    import chebyshev_recurrence_ctrl_pkg::*;
#(
    parameter int IW = 33,
    parameter int WL = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [WL-1:0] dout,
    output logic                 clip
);

    localparam logic signed [IW-1:0] MAX_V = IW'(sat_max(WL));
    localparam logic signed [IW-1:0] MIN_V = IW'(sat_min(WL));

    always_comb begin
        clip = 1'b0;
        dout = din[WL-1:0];
        if (din > MAX_V) begin
            dout = MAX_V[WL-1:0];
            clip = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[WL-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/chebyshev_recurrence_ctrl.sv
// Sequences one shared multiply/subtract/saturate datapath to stream Chebyshev
// terms T_0..T_order of a fixed-point argument over a valid/ready port.
module chebyshev_recurrence_ctrl
    import chebyshev_recurrence_ctrl_pkg::*;
#(
    parameter int WL     = 16,
    parameter int I_BITS = 4,
    parameter int N_MAX  = 15,
    parameter int CW     = $clog2(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WL-1:0] x,
    input  logic [CW-1:0] order,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_data,
    output logic [CW-1:0] out_index,
    output logic          out_last,
    output logic          sat_flag,
    output logic          done
);

    localparam int FRAC = WL - I_BITS;
    localparam logic signed [WL-1:0] ONE = {{(I_BITS-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, data/index/last are held.

    state_t state, state_next;

    logic signed [WL-1:0] x_q;
    logic signed [WL-1:0] t_prev;
    logic signed [WL-1:0] t_cur;
    logic [CW-1:0]        order_q;
    logic [CW-1:0]        k;
    logic                 sat_q;
    logic                 done_q;

    logic [CW-1:0]          order_clamped;
    logic signed [2*WL-1:0] x_ext;
    logic signed [2*WL-1:0] t_ext;
    logic signed [2*WL-1:0] prod;
    logic signed [2*WL-1:0] scaled;
    logic signed [2*WL:0]   diff;
    logic signed [WL-1:0]   clipped;
    logic                   clipped_flag;
    logic signed [WL-1:0]   next_term;
    logic                   beat;
    logic                   at_last;

    assign order_clamped = (order > CW'(N_MAX)) ? CW'(N_MAX) : order;
    assign beat          = (state == EMIT) && out_ready;
    assign at_last       = (k == order_q);

    // Shifting by FRAC-1 instead of FRAC folds the factor of two into the scale.
    assign x_ext  = {{WL{x_q[WL-1]}}, x_q};
    assign t_ext  = {{WL{t_cur[WL-1]}}, t_cur};
    assign prod   = x_ext * t_ext;
    assign scaled = prod >>> (FRAC - 1);
    assign diff   = {scaled[2*WL-1], scaled} - {{(WL+1){t_prev[WL-1]}}, t_prev};

    chebyshev_clip #(
        .IW (2*WL + 1),
        .WL (WL)
    ) u_clip (
        .din  (diff),
        .dout (clipped),
        .clip (clipped_flag)
    );

    assign next_term = (k == '0) ? x_q : clipped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EMIT;
            EMIT:    if (out_ready) state_next = at_last ? IDLE : CALC;
            CALC:    state_next = EMIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            order_q <= '0;
            t_prev  <= '0;
            t_cur   <= '0;
            k       <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        order_q <= order_clamped;
                        t_prev  <= '0;
                        t_cur   <= ONE;
                        k       <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                EMIT: begin
                    if (beat && at_last) done_q <= 1'b1;
                end
                CALC: begin
                    t_prev <= t_cur;
                    t_cur  <= next_term;
                    k      <= k + 1'b1;
                    if (clipped_flag && (k != '0)) sat_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_data  = t_cur;
    assign out_index = k;
    assign out_last  = (state == EMIT) && at_last;
    assign sat_flag  = sat_q;
    assign done      = done_q;

endmodule
